// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the decode-stage register file and its scoreboard.
package regfile_pkg;

    localparam int REG_ZERO  = 0;
    localparam int DEF_W     = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_NRD   = 2;

    // Low bit index of field k in a vector of equal-width packed fields.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: marks registers with an outstanding producer and
// reports per-read-port hazards, masked by any same-cycle writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int NRD   = DEF_NRD
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic              busy_any
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // A new issue outranks a same-cycle writeback: the newer producer is still pending.
    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        if (i == REG_ZERO) begin : g_zero
            assign w_busy_nxt[i] = 1'b0;
        end else begin : g_live
            logic w_set;
            logic w_clr;
            assign w_set = issue_en && (issue_addr == AW'(i));
            assign w_clr = (wa_en && (wa_addr == AW'(i))) || (wb_en && (wb_addr == AW'(i)));
            assign w_busy_nxt[i] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[i]);
        end
    end

    // Busy-bit state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_busy <= {NREGS{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] w_addr;
        assign w_addr     = rd_addr[slice_lo(k, AW) +: AW];
        assign rd_busy[k] = r_busy[w_addr]
                            && !(wa_en && (wa_addr == w_addr))
                            && !(wb_en && (wb_addr == w_addr));
    end

    assign busy_any = |rd_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass (port B over port A) and a
// busy scoreboard for the hazard unit. Register 0 is hardwired to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int NRD   = DEF_NRD
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*W-1:0]  rd_data,
    output logic [NRD-1:0]    rd_busy,
    output logic              busy_any,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_addr,
    input  logic [W-1:0]      wa_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [W-1:0]      wb_data,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr
);

    logic [W-1:0] r_regs [NREGS];

    // Storage writes; port B is applied last so it wins an address conflict.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {W{1'b0}};
            end
        end else begin
            if (wa_en && (wa_addr != AW'(REG_ZERO))) begin
                r_regs[wa_addr] <= wa_data;
            end
            if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
                r_regs[wb_addr] <= wb_data;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rd_addr[slice_lo(k, AW) +: AW];
        assign rd_data[slice_lo(k, W) +: W] =
            (w_addr == AW'(REG_ZERO))          ? {W{1'b0}} :
            (wb_en && (wb_addr == w_addr))     ? wb_data   :
            (wa_en && (wa_addr == w_addr))     ? wa_data   :
                                                 r_regs[w_addr];
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD)
    ) u_scoreboard (
        .CLK        (CLK),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_busy    (rd_busy),
        .busy_any   (busy_any)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, randomized run against
// an array model, and a reset sequence on a 4-port / 16-register configuration.
module tb_regfile_sb;

    logic        CLK;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        busy_any;
    logic        wa_en, wb_en, issue_en;
    logic [4:0]  wa_addr, wb_addr, issue_addr;
    logic [31:0] wa_data, wb_data;

    logic         reset2;
    logic [15:0]  rd_addr2;
    logic [127:0] rd_data2;
    logic [3:0]   rd_busy2;
    logic         busy_any2;
    logic         wa_en2, wb_en2, issue_en2;
    logic [3:0]   wa_addr2, wb_addr2, issue_addr2;
    logic [31:0]  wa_data2, wb_data2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    typedef struct {
        logic        rst;
        logic        wae; logic [4:0] waa; logic [31:0] wad;
        logic        wbe; logic [4:0] wba; logic [31:0] wbd;
        logic        ise; logic [4:0] isa;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] ed0; logic [31:0] ed1;
        logic        eb0; logic eb1;
    } vec_t;

    vec_t tbl [23];

    regfile_sb #(.W(32), .NREGS(32), .AW(5), .NRD(2)) dut (
        .CLK(CLK), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .busy_any(busy_any),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    regfile_sb #(.W(32), .NREGS(16), .AW(4), .NRD(4)) dut2 (
        .CLK(CLK), .reset(reset2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .rd_busy(rd_busy2), .busy_any(busy_any2),
        .wa_en(wa_en2), .wa_addr(wa_addr2), .wa_data(wa_data2),
        .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
        .issue_en(issue_en2), .issue_addr(issue_addr2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the model state plus this cycle's write ports.
    task automatic model_check();
        logic [4:0]  a;
        logic [31:0] ed;
        bit          eb, any;
        any = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            if (a == 5'd0)                        ed = 32'h0;
            else if (wb_en && wb_addr == a)       ed = wb_data;
            else if (wa_en && wa_addr == a)       ed = wa_data;
            else                                  ed = m_regs[a];
            eb = (a != 5'd0) && m_busy[a] && !(wa_en && wa_addr == a) && !(wb_en && wb_addr == a);
            any = any | eb;
            chk($sformatf("model_data_p%0d_r%0d", k, a), rd_data[k*32 +: 32], ed);
            chk($sformatf("model_busy_p%0d_r%0d", k, a), 32'(rd_busy[k]), 32'(eb));
        end
        chk("model_busy_any", 32'(busy_any), 32'(any));
    endtask

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wa_en && wa_addr != 5'd0) begin m_regs[wa_addr] = wa_data; m_busy[wa_addr] = 1'b0; end
            if (wb_en && wb_addr != 5'd0) begin m_regs[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
            if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    // Called at the negedge: check against the model, advance it, cross the posedge.
    task automatic model_step();
        model_check();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle1();
        reset = 1'b0; wa_en = 1'b0; wb_en = 1'b0; issue_en = 1'b0;
        wa_addr = 5'd0; wb_addr = 5'd0; issue_addr = 5'd0;
        wa_data = 32'h0; wb_data = 32'h0;
    endtask

    task automatic idle2();
        reset2 = 1'b0; wa_en2 = 1'b0; wb_en2 = 1'b0; issue_en2 = 1'b0;
        wa_addr2 = 4'd0; wb_addr2 = 4'd0; issue_addr2 = 4'd0;
        wa_data2 = 32'h0; wb_data2 = 32'h0; rd_addr2 = 16'h0;
    endtask

    initial begin
        //           rst   wae   waa   wad           wbe   wba   wbd           ise   isa   ra0   ra1   ed0           ed1           eb0   eb1
        tbl[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd31,32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd1, 32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'd5, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b1, 5'd7, 32'h55555555, 1'b0, 5'd0, 5'd7, 5'd7, 32'h55555555, 32'h55555555, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h55555555, 32'h55555555, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h0,        32'h55555555, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 5'd3, 32'h11,       1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd9, 32'h11,       32'hDEADBEEF, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h11,       32'h11,       1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'h11,       1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h11,       1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 5'd10,32'h77,       1'b1, 5'd11,32'h88,       1'b1, 5'd4, 5'd10,5'd11,32'h77,       32'h88,       1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 5'd12,32'h99,       1'b1, 5'd13,32'hAB,       1'b1, 5'd6, 5'd4, 5'd10,32'h0,        32'h77,       1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd12,32'h0,        32'h0,        1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd10,5'd13,32'h0,        32'h0,        1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd6, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd11,32'h0,        32'h0,        1'b0, 1'b0};

        idle1();
        idle2();
        rd_addr = 10'h0;
        reset   = 1'b1;
        reset2  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset  = 1'b0;
        reset2 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end

        // Reset state: every address on both ports reads zero and not busy.
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            @(negedge CLK);
            chk($sformatf("rst_data_r%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("rst_data_r%0d", 31 - a), rd_data[63:32], 32'h0);
            chk("rst_busy", 32'(rd_busy), 32'h0);
            chk("rst_busy_any", 32'(busy_any), 32'h0);
            @(posedge CLK);
            #1;
        end

        // Directed vectors; the model is kept in step so the random phase continues from here.
        for (int i = 0; i < 23; i++) begin
            reset = tbl[i].rst;
            wa_en = tbl[i].wae; wa_addr = tbl[i].waa; wa_data = tbl[i].wad;
            wb_en = tbl[i].wbe; wb_addr = tbl[i].wba; wb_data = tbl[i].wbd;
            issue_en = tbl[i].ise; issue_addr = tbl[i].isa;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            @(negedge CLK);
            chk($sformatf("vec%0d_data_p0", i), rd_data[31:0],  tbl[i].ed0);
            chk($sformatf("vec%0d_data_p1", i), rd_data[63:32], tbl[i].ed1);
            chk($sformatf("vec%0d_busy_p0", i), 32'(rd_busy[0]), 32'(tbl[i].eb0));
            chk($sformatf("vec%0d_busy_p1", i), 32'(rd_busy[1]), 32'(tbl[i].eb1));
            chk($sformatf("vec%0d_busy_any", i), 32'(busy_any), 32'(tbl[i].eb0 | tbl[i].eb1));
            model_step();
        end

        // Randomized traffic with a narrow address window to force collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] pick [4];
            reset    = ($urandom_range(0, 59) == 0);
            wa_en    = 1'($urandom_range(0, 1));
            wa_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wa_data  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            wb_en    = 1'($urandom_range(0, 1));
            wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : 5'($urandom_range(0, 7));
            wb_data  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            issue_en = ($urandom_range(0, 2) == 0);
            issue_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 5'($urandom_range(0, 7));
            pick[0] = wa_addr; pick[1] = wb_addr; pick[2] = issue_addr; pick[3] = 5'($urandom_range(0, 31));
            rd_addr = {pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)]};
            @(negedge CLK);
            model_step();
        end
        idle1();

        // Four-port, 16-register configuration: fill, check, then reset with concurrent traffic.
        for (int i = 1; i < 16; i++) begin
            wa_en2 = 1'b1; wa_addr2 = 4'(i); wa_data2 = 32'h1000_0000 + 32'(i);
            issue_en2 = (i == 4); issue_addr2 = 4'd4;
            @(posedge CLK);
            #1;
        end
        idle2();
        rd_addr2 = {4'd0, 4'd6, 4'd5, 4'd4};
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            int a;
            a = (k == 3) ? 0 : 4 + k;
            chk($sformatf("cfg2_data_p%0d", k), rd_data2[k*32 +: 32], (a == 0) ? 32'h0 : 32'h1000_0000 + 32'(a));
            chk($sformatf("cfg2_busy_p%0d", k), 32'(rd_busy2[k]), (a == 4) ? 32'h1 : 32'h0);
        end
        chk("cfg2_busy_any", 32'(busy_any2), 32'h1);
        @(posedge CLK);
        #1;
        reset2 = 1'b1;
        wa_en2 = 1'b1; wa_addr2 = 4'd2; wa_data2 = 32'h0000_FFFF;
        wb_en2 = 1'b1; wb_addr2 = 4'd3; wb_data2 = 32'h0000_1234;
        issue_en2 = 1'b1; issue_addr2 = 4'd8;
        @(posedge CLK);
        #1;
        idle2();
        for (int base = 0; base < 16; base += 4) begin
            rd_addr2 = {4'(base + 3), 4'(base + 2), 4'(base + 1), 4'(base)};
            @(negedge CLK);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cfg2_rst_data_r%0d", base + k), rd_data2[k*32 +: 32], 32'h0);
                chk($sformatf("cfg2_rst_busy_r%0d", base + k), 32'(rd_busy2[k]), 32'h0);
            end
            chk("cfg2_rst_busy_any", 32'(busy_any2), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port MIPS register file with write-to-read bypass and a per-register busy scoreboard.
- Sits in the decode stage. Read ports feed operand fetch.
- Write port A is the ALU writeback; write port B is the memory/load writeback.
- The scoreboard flags operands whose producer (e.g. an outstanding load) has not yet written back, so the hazard unit can stall.

Parameters:
W, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
AW, 5, address width; must equal clog2(NREGS)
NRD, 2, number of read ports (1..4)

Ports:
CLK  input  1  clock
reset  input  1  synchronous, active-high reset
rd_addr  input  NRD*AW  packed read addresses; port k at bits [k*AW +: AW]
rd_data  output  NRD*W  packed read data; port k at bits [k*W +: W]; combinational
rd_busy  output  NRD  per-port busy flag; combinational
busy_any  output  1  OR of rd_busy
wa_en  input  1  write port A enable
wa_addr  input  AW  write port A address
wa_data  input  W  write port A data
wb_en  input  1  write port B enable
wb_addr  input  AW  write port B address
wb_data  input  W  write port B data
issue_en  input  1  mark destination as pending
issue_addr  input  AW  destination register to mark busy

Behaviour:
- Reset (sync, active-high, at posedge CLK):
  - all NREGS registers cleared to 0; all busy bits cleared.
  - reset overrides writes and issue in the same cycle.
  - reset mid-operation discards any pending writes and busy state.
- Register 0:
  - always reads 0; writes to it are discarded.
  - issue to address 0 is ignored; rd_busy for address 0 is always 0.
- Writes commit at posedge CLK when the enable is high. Any data value is committed, including 0.
- Dual-write conflict (wa_en && wb_en && wa_addr==wb_addr, nonzero): port B data is stored; port A data is dropped.
- Read path: zero-latency combinational read. For each port k, in priority order:
  1. addr==0 -> 0
  2. wb_en && wb_addr==addr -> wb_data
  3. wa_en && wa_addr==addr -> wa_data
  4. otherwise the stored value
- Scoreboard: one busy bit per register.
  - Set at posedge when issue_en && issue_addr!=0.
  - Cleared at posedge when either write port writes that address (wa or wb).
  - Simultaneous issue and write to the same address: the bit stays set (new producer wins), and the write data is still committed.
- rd_busy[k] = busy[addr_k] && !(wa_en && wa_addr==addr_k) && !(wb_en && wb_addr==addr_k).
  - A same-cycle writeback therefore clears the hazard; the bypassed data is valid.
- Re-issue of an already-busy register keeps it busy (no counter; single outstanding producer per register).
- Out-of-range addresses cannot occur: NREGS == 2**AW.
- No X propagation: every output is defined after the first reset.

Decomposition:
- Package regfile_pkg:
  - constants REG_ZERO=0 and default W/AW/NREGS
  - helper function for packed-slice extraction
- Sub-module regfile_scoreboard: holds the NREGS busy bits, set/clear logic and per-port rd_busy generation.
- regfile_sb instantiates regfile_scoreboard plus the storage array and bypass muxes.

Test Plan:
1. Reset then read all addresses on both ports -> every rd_data==0, rd_busy==0, busy_any==0.
2. wa write r5=0x0000_0000 after r5 was 0x1234_5678 -> next cycle r5 reads 0 (zero writes are committed). Write r0=0xFFFF_FFFF -> r0 reads 0.
3. Same cycle wa(r7,0xAAAA_AAAA) and wb(r7,0x5555_5555) -> rd_data on r7 is 0x5555_5555 in that cycle (bypass) and in later cycles (stored).
4. issue r9; next cycle read r9 -> rd_busy=1, busy_any=1. Then wb write r9=0xDEAD_BEEF -> same cycle rd_busy=0 and rd_data=0xDEAD_BEEF; next cycle busy clear.
5. issue r3 and wa write r3=0x11 in the same cycle -> next cycle r3 reads 0x11 with rd_busy=1.
6. Issue r4, write several registers, assert reset for one cycle with concurrent writes -> all registers 0 and all busy clear afterwards. Repeat with NRD=4, NREGS=16, AW=4.
